// File: rtl/in_cond_if.sv
// Pad-side raw signals and their conditioned, clock-domain-safe counterparts.
// The slave side belongs to in_cond; the master side belongs to whoever drives the pads.
interface in_cond_if;
  logic [3:0] btn_core;
  logic       uart_sin_core;
  logic       spi_miso_core;
  logic       rst_n_sync;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       uart_sin_sync;
  logic       spi_miso_sync;

  modport master (
    output btn_core, uart_sin_core, spi_miso_core,
    input  rst_n_sync, btn_level, btn_press, btn_release, uart_sin_sync, spi_miso_sync
  );

  modport slave (
    input  btn_core, uart_sin_core, spi_miso_core,
    output rst_n_sync, btn_level, btn_press, btn_release, uart_sin_sync, spi_miso_sync
  );
endinterface

// File: rtl/in_cond.sv
// Input conditioning: reset synchroniser, 2-flop serial synchronisers and
// four debounced button channels with registered press/release pulses.
module in_cond #(
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  in_cond_if.slave io
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rst_s1_q, rst_s2_q;
  logic             uart_s1_q, uart_s2_q;
  logic             spi_s1_q, spi_s2_q;
  logic [3:0]       btn_s1_q, btn_s2_q;
  logic [3:0]       lvl_q, lvl_d;
  logic [3:0]       press_q, press_d;
  logic [3:0]       release_q, release_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Reset synchroniser: asserts with rst_n, releases two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= 1'b0;
    end else begin
      rst_s1_q <= 1'b1;
      rst_s2_q <= rst_s1_q;
    end
  end

  // Serial synchronisers; UART resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_s1_q <= 1'b1;
      uart_s2_q <= 1'b1;
      spi_s1_q  <= 1'b0;
      spi_s2_q  <= 1'b0;
    end else begin
      uart_s1_q <= io.uart_sin_core;
      uart_s2_q <= uart_s1_q;
      spi_s1_q  <= io.spi_miso_core;
      spi_s2_q  <= spi_s1_q;
    end
  end

  // Debounce state is implicit in cnt: zero means stable, non-zero means counting.
  // Comparing against CNT_LAST in every state also covers DEB_CYCLES==1 directly.
  always_comb begin
    lvl_d     = lvl_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (btn_s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]     = '0;
        lvl_d[i]     = btn_s2_q[i];
        press_d[i]   = btn_s2_q[i];
        release_d[i] = ~btn_s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      lvl_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      btn_s1_q  <= io.btn_core;
      btn_s2_q  <= btn_s1_q;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign io.rst_n_sync    = rst_s2_q;
  assign io.uart_sin_sync = uart_s2_q;
  assign io.spi_miso_sync = spi_s2_q;
  assign io.btn_level     = lvl_q;
  assign io.btn_press     = press_q;
  assign io.btn_release   = release_q;

endmodule

// File: tb/tb_in_cond.sv
// Directed bench for in_cond: expected output waveforms are queued per cycle when
// stimulus is applied and compared by a monitor just after each rising edge.
module tb_in_cond;

  typedef struct {
    int          at;
    logic [14:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   last_at = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  in_cond_if io ();

  in_cond #(.DEB_CYCLES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(logic r, logic [3:0] l, logic [3:0] p,
                                     logic [3:0] rl, logic u, logic s);
    return {r, l, p, rl, u, s};
  endfunction

  function automatic logic [14:0] obs();
    return {io.rst_n_sync, io.btn_level, io.btn_press, io.btn_release,
            io.uart_sin_sync, io.spi_miso_sync};
  endfunction

  task automatic fill_to(input int upto, input logic [14:0] v);
    while (last_at < upto) begin
      last_at++;
      sb.push_back('{at: last_at, v: v});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: one expected vector per queued cycle.
  initial begin
    exp_t e;
    logic [14:0] o;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        e = sb.pop_front();
        o = obs();
        checks++;
        assert (o === e.v)
        else begin
          errors++;
          $error("FAIL sb_cyc%0d observed %b expected %b", cyc, o, e.v);
        end
      end
    end
  end

  initial begin
    logic [14:0] RV, IDLE, L0, L1, L2, U, cur, o;
    int c, e, f;
    RV   = pk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    IDLE = pk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    io.btn_core      = 4'b0000;
    io.uart_sin_core = 1'b1;
    io.spi_miso_core = 1'b0;

    // Reset held for 5 cycles, released, rst_n_sync rises on the 2nd edge
    fill_to(5, RV);
    tick(5);
    rst_n = 1'b1;
    fill_to(cyc + 1, RV);
    fill_to(cyc + 4, IDLE);
    tick(4);

    // Asynchronous re-assertion between edges
    rst_n = 1'b0;
    #1;
    o = obs();
    checks++;
    assert (o === RV)
    else begin
      errors++;
      $error("FAIL async_rst observed %b expected %b", o, RV);
    end
    fill_to(cyc + 2, RV);
    tick(2);
    rst_n = 1'b1;
    fill_to(cyc + 1, RV);
    fill_to(cyc + 4, IDLE);
    tick(4);

    // Clean press on button 0
    c = cyc; e = c + 1;
    io.btn_core = 4'b0001;
    L0 = pk(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0);
    fill_to(e + 4, IDLE);
    fill_to(e + 5, pk(1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0));
    fill_to(e + 8, L0);
    tick(e + 8 - cyc);

    // Bounce on button 1: 1,1,1,0 then held 1
    c = cyc; f = c + 5;
    L1 = pk(1'b1, 4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0);
    fill_to(f + 4, L0);
    fill_to(f + 5, pk(1'b1, 4'b0011, 4'b0010, 4'b0000, 1'b1, 1'b0));
    fill_to(f + 8, L1);
    io.btn_core = 4'b0011;
    tick(3);
    io.btn_core = 4'b0001;
    tick(1);
    io.btn_core = 4'b0011;
    tick(f + 8 - cyc);

    // Buttons 2 and 3 pressed together, then released together
    c = cyc; e = c + 1;
    io.btn_core = 4'b1111;
    L2 = pk(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    fill_to(e + 4, L1);
    fill_to(e + 5, pk(1'b1, 4'b1111, 4'b1100, 4'b0000, 1'b1, 1'b0));
    fill_to(e + 8, L2);
    tick(e + 8 - cyc);
    c = cyc; e = c + 1;
    io.btn_core = 4'b0011;
    fill_to(e + 4, L2);
    fill_to(e + 5, pk(1'b1, 4'b0011, 4'b0000, 4'b1100, 1'b1, 1'b0));
    fill_to(e + 8, L1);
    tick(e + 8 - cyc);

    // UART 1->0 appears after the edge following its first sample
    c = cyc;
    io.uart_sin_core = 1'b0;
    U = pk(1'b1, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fill_to(c + 1, L1);
    fill_to(c + 4, U);
    tick(4);

    // SPI toggling every 3 cycles, reproduced 2 cycles later
    cur = U;
    for (int k = 0; k < 6; k++) begin
      c = cyc;
      io.spi_miso_core = ~io.spi_miso_core;
      fill_to(c + 1, cur);
      cur[0] = io.spi_miso_core;
      fill_to(c + 3, cur);
      tick(3);
    end

    // Return serial lines to idle and release buttons 0 and 1
    c = cyc;
    io.uart_sin_core = 1'b1;
    io.spi_miso_core = 1'b0;
    io.btn_core      = 4'b0000;
    fill_to(c + 1, cur);
    fill_to(c + 5, L1);
    fill_to(c + 6, pk(1'b1, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1'b0));
    fill_to(c + 9, IDLE);
    tick(9);

    // Reset asserted with button 0 mid-count (cnt==2), then held press after release
    c = cyc;
    io.btn_core = 4'b0001;
    fill_to(c + 4, IDLE);
    tick(4);
    rst_n = 1'b0;
    #1;
    o = obs();
    checks++;
    assert (o === RV)
    else begin
      errors++;
      $error("FAIL rst_midcount observed %b expected %b", o, RV);
    end
    fill_to(c + 7, RV);
    tick(3);
    rst_n = 1'b1;
    fill_to(c + 8, RV);
    fill_to(c + 12, IDLE);
    fill_to(c + 13, pk(1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0));
    fill_to(c + 16, pk(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0));
    tick(16 - (cyc - c));

    // Every queued expectation must have been consumed within a bounded wait
    for (int w = 0; w < 20 && sb.size() > 0; w++) tick(1);
    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL sb_drain observed %0d left expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/in_cond.md
# in_cond

Input conditioning stage directly downstream of the input pad ring. It takes the raw, asynchronous pad-side core signals (`rst_n_core`, `btn_core[3:0]`, `uart_sin_core`, `spi_miso_core`) and hands the rest of the core clean, clock-domain-safe versions:
- a reset that asserts asynchronously and deasserts synchronously;
- debounced button levels with one-cycle press and release pulses;
- 2-flop-synchronised serial inputs.

## Interface
Parameters:
- `DEB_CYCLES`, default 50000: number of consecutive synchronised samples a button must hold a new value before it is accepted; legal range ≥1.
- `CNT_W`, default 16: debounce counter width; must satisfy 2^CNT_W ≥ DEB_CYCLES.

Ports:
- `clk` input 1: core clock (from `clk_core`); the only clock.
- `rst_n` input 1: reset, asynchronous, active-low (from `rst_n_core`); resets every flop in the block.
- `btn_core` input 4: raw buttons, active-high, asynchronous to `clk`.
- `uart_sin_core` input 1: raw UART RX line, asynchronous.
- `spi_miso_core` input 1: raw SPI MISO, asynchronous.
- `rst_n_sync` output 1: core reset; asserts asynchronously, deasserts synchronously.
- `btn_level` output 4: debounced button state.
- `btn_press` output 4: one-cycle pulse on a debounced 0→1 transition.
- `btn_release` output 4: one-cycle pulse on a debounced 1→0 transition.
- `uart_sin_sync` output 1: synchronised UART RX.
- `spi_miso_sync` output 1: synchronised MISO.

## Operation
- **Reset synchroniser**
  - 2-flop chain clocked by `clk`, D input of the first flop tied to 1, both flops cleared by `rst_n`.
  - `rst_n_sync` = second flop.
- **Serial inputs**
  - Each input goes through 2 flops, and the second flop drives the output directly. No filtering.
  - `uart_sin` chain resets to 1 (line idle). `spi_miso` chain resets to 0.
- **Buttons** (4 independent, identical channels). Each channel has:
  - a 2-flop synchroniser, output `s`, reset 0;
  - a registered level `lvl`, which drives `btn_level`, reset 0;
  - a counter `cnt` of width `CNT_W`, reset 0;
  - registered pulses `btn_press` and `btn_release`, reset 0.
- **Per-channel FSM**, encoded implicitly by `cnt`:
  - STABLE (`cnt`==0, `s`==`lvl`): hold everything.
  - STABLE → COUNTING when `s`≠`lvl`; `cnt` becomes 1. If DEB_CYCLES==1, go straight to ACCEPT instead.
  - COUNTING with `s`==`lvl` (glitch): `cnt`←0 and return to STABLE. No output change.
  - COUNTING with `s`≠`lvl` and `cnt`<DEB_CYCLES-1: `cnt`++.
  - COUNTING with `s`≠`lvl` and `cnt`==DEB_CYCLES-1: ACCEPT.
  - ACCEPT: `lvl`←`s`, `cnt`←0.
    - `btn_press`←1 if the new `lvl`=1, otherwise `btn_release`←1.
    - The pulse is registered and lasts exactly one cycle.
- **Pulse rules**
  - Pulses are 0 in every cycle except the one following an ACCEPT edge.
  - `btn_press` and `btn_release` are never both 1 on one channel.
- **Counter behaviour**
  - The counter never exceeds DEB_CYCLES-1, so there is no wrap-around.
  - A bounce at any count restarts the count from 0.
- **Simultaneous events**
  - Channels are fully independent. Several buttons may accept on the same edge, giving multiple pulse bits set at once.
- **Reset mid-operation**
  - Assertion of `rst_n` immediately clears every flop.
  - While in reset, all outputs take their reset values, a partial count is discarded, and no pulse is emitted.
  - After release, a button that is still held is detected as a normal press.

## Timing
- **Reset values**:
  - `rst_n_sync`=0, `btn_level`=0, `btn_press`=0, `btn_release`=0;
  - `uart_sin_sync`=1, `spi_miso_sync`=0.
- **`rst_n_sync`**
  - Goes to 0 combinationally on `rst_n` falling.
  - Goes to 1 on the 2nd rising `clk` edge after `rst_n` rises.
- **Serial inputs**: an input change first sampled at edge E appears on the output after edge E+1. Latency is 2 cycles.
- **Button acceptance**
  - A change first sampled at edge E is accepted, and `btn_level` and the pulse update, at edge E+DEB_CYCLES+1.
  - This requires the input to be the new value at sampling edges E .. E+DEB_CYCLES-1.
  - The pulse deasserts at edge E+DEB_CYCLES+2.
- **Glitch rejection**: a glitch sampled on fewer than DEB_CYCLES consecutive edges never changes `btn_level`.

## Test plan
- **Reset release**: hold `rst_n`=0 for 5 cycles, then release.
  - All outputs hold their reset values during reset.
  - `rst_n_sync` rises on the 2nd edge after release.
  - Re-asserting `rst_n` mid-cycle drops `rst_n_sync` immediately, without waiting for a clock edge.
- **Clean press** (DEB_CYCLES=4): `btn_core[0]` 0→1, first sampled at edge 1 and held.
  - `btn_level[0]`=1 and `btn_press[0]`=1 after edge 6.
  - `btn_press[0]`=0 after edge 7.
  - Other channels stay 0.
- **Bounce** (DEB_CYCLES=4): `btn_core[1]`=1 for 3 sampled edges, 0 for 1 edge, then 1 held.
  - No output change during the bounce.
  - `btn_level[1]` rises 5 edges after the final 0→1 sample.
  - Exactly one `btn_press[1]` pulse.
- **Release and simultaneity** (DEB_CYCLES=4): buttons 2 and 3 held pressed, then both released on the same edge.
  - `btn_release`=4'b1100 for exactly one cycle.
  - `btn_press` stays 0.
- **Serial synchronisers**
  - `uart_sin_core` 1→0 sampled at edge E: `uart_sin_sync`=0 after edge E+1.
  - `spi_miso_core` toggling every 3 cycles is reproduced on `spi_miso_sync` delayed by 2 cycles.
- **Reset mid-count** (DEB_CYCLES=4): reset asserted at `cnt`=2 with `btn_core[0]` held at 1.
  - Outputs return to their reset values immediately.
  - After release, the press is accepted at edge E+5, where E is the first sampling edge after reset release.
  - One `btn_press` pulse is produced.
